// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter / branch stage.
// Holds the FSM state enum, branch condition codes and the default branch target table.
package pc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    COND_ALWAYS = 3'd0,
    COND_ZERO   = 3'd1,
    COND_NZERO  = 3'd2,
    COND_LT     = 3'd3,
    COND_NLT    = 3'd4,
    COND_CARRY  = 3'd5,
    COND_ADD    = 3'd6,
    COND_NEVER  = 3'd7
  } cond_e;

  localparam int LUT_DEPTH = 16;

  // Entries are 16 bits wide and truncated to the PC width at the lookup.
  localparam logic [15:0] BRANCH_TABLE [0:LUT_DEPTH-1] = '{
    16'd16,  16'd100, 16'd50,  16'd200,
    16'd37,  16'd1023, 16'd0,  16'd300,
    16'd512, 16'd12,  16'd700, 16'd999,
    16'd64,  16'd128, 16'd255, 16'd1000
  };

endpackage

// File: rtl/branch_lut.sv
// Combinational 16-entry branch target ROM; maps the instruction's LUT index to a PC target.
// Contents come from the default table in pc_pkg.
module branch_lut
  import pc_pkg::*;
#(
  parameter int PC_W = 10
) (
  input  logic [3:0]      i_LutIdx,
  output logic [PC_W-1:0] o_Target
);

  logic [15:0] w_entry;

  always_comb begin
    w_entry  = BRANCH_TABLE[i_LutIdx];
    o_Target = PC_W'(w_entry);
  end

endmodule

// File: rtl/pc_branch_unit.sv
// Program counter, branch resolution and run/halt sequencing.
// Optional taken-branch statistics counter enabled by defining PC_BRANCH_STATS_EN.
module pc_branch_unit
  import pc_pkg::*;
#(
  parameter int              PC_W       = 10,
  parameter logic [PC_W-1:0] START_ADDR = '0
) (
  input  logic            i_Clk,
  input  logic            i_Reset,
  input  logic            i_Start,
  input  logic            i_Halt,
  input  logic            i_Stall,
  input  logic            i_Branch,
  input  logic [2:0]      i_Cond,
  input  logic [3:0]      i_LutIdx,
  input  logic            i_Carry,
  input  logic            i_LessThan,
  input  logic            i_Zero,
  input  logic            i_AddFlag,
`ifdef PC_BRANCH_STATS_EN
  output logic [15:0]     o_TakenCount,
`endif
  output logic [PC_W-1:0] o_PC,
  output logic            o_Taken,
  output logic            o_Done
);

  state_e          r_state;
  state_e          w_nextState;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_nextPc;
  logic            r_taken;
  logic            w_nextTaken;
  logic [PC_W-1:0] w_target;
  logic            w_condTrue;
  logic            w_enterRun;
  logic            w_setTaken;

  branch_lut #(.PC_W(PC_W)) u_lut (
    .i_LutIdx (i_LutIdx),
    .o_Target (w_target)
  );

  always_comb begin
    w_condTrue = 1'b0;
    case (cond_e'(i_Cond))
      COND_ALWAYS: w_condTrue = 1'b1;
      COND_ZERO:   w_condTrue = i_Zero;
      COND_NZERO:  w_condTrue = !i_Zero;
      COND_LT:     w_condTrue = i_LessThan;
      COND_NLT:    w_condTrue = !i_LessThan;
      COND_CARRY:  w_condTrue = i_Carry;
      COND_ADD:    w_condTrue = i_AddFlag;
      default:     w_condTrue = 1'b0;
    endcase
  end

  // Priority inside RUN: stall, then halt, then branch, then sequential step.
  always_comb begin
    w_nextState = r_state;
    w_nextPc    = r_pc;
    w_nextTaken = r_taken;
    w_enterRun  = 1'b0;
    w_setTaken  = 1'b0;
    case (r_state)
      IDLE, HALT: begin
        if (i_Start) begin
          w_nextState = RUN;
          w_nextPc    = START_ADDR;
          w_nextTaken = 1'b0;
          w_enterRun  = 1'b1;
        end
      end
      RUN: begin
        if (i_Stall) begin
          w_nextPc = r_pc;
        end else if (i_Halt) begin
          w_nextState = HALT;
          w_nextTaken = 1'b0;
        end else if (i_Branch && w_condTrue) begin
          w_nextPc    = w_target;
          w_nextTaken = 1'b1;
          w_setTaken  = 1'b1;
        end else begin
          w_nextPc    = r_pc + PC_W'(1);
          w_nextTaken = 1'b0;
        end
      end
      default: begin
        w_nextState = IDLE;
        w_nextPc    = START_ADDR;
        w_nextTaken = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      r_state <= IDLE;
      r_pc    <= START_ADDR;
      r_taken <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_pc    <= w_nextPc;
      r_taken <= w_nextTaken;
    end
  end

`ifdef PC_BRANCH_STATS_EN
  logic [15:0] r_takenCount;

  // Counts taken branches since the run began, sticking at all-ones.
  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      r_takenCount <= '0;
    end else if (w_enterRun) begin
      r_takenCount <= '0;
    end else if (w_setTaken && (r_takenCount != 16'hFFFF)) begin
      r_takenCount <= r_takenCount + 16'd1;
    end
  end

  assign o_TakenCount = r_takenCount;
`endif

  assign o_PC    = r_pc;
  assign o_Taken = r_taken;
  assign o_Done  = (r_state == HALT);

endmodule
